// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 data mux: walks the enabled channels, holds each
// for DWELL+1 cycles and captures the mux output at the end of every dwell.
module mux_scan_ctrl #(
  parameter int WIDTH   = 1,
  parameter int DWELL_W = 8
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               START,
  input  logic               STOP,
  input  logic               CONT,
  input  logic [7:0]         MASK,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic [WIDTH-1:0]   Y_IN,
  output logic               CSn,
  output logic [2:0]         A,
  output logic [WIDTH-1:0]   SAMPLE,
  output logic [2:0]         SAMPLE_CH,
  output logic               SAMPLE_VLD,
  output logic               BUSY,
  output logic               DONE
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DWELL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         a_q, a_d;
  logic               csn_q, csn_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               vld_q, vld_d;
  logic [WIDTH-1:0]   sample_q, sample_d;
  logic [2:0]         sample_ch_q, sample_ch_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [7:0]         mask_q, mask_d;
  logic               cont_q, cont_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic [2:0] next_idx;
  logic       wrap;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

  // Circular search above cur; descending offsets so the nearest set bit wins.
  // With no other bit set the result is cur itself, i.e. a wrap.
  function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] idx;
    next_set = cur;
    for (int i = 7; i >= 1; i--) begin
      idx = cur + 3'(i);
      if (m[idx]) next_set = idx;
    end
  endfunction

  assign next_idx = next_set(mask_q, a_q);
  assign wrap     = (next_idx <= a_q);

  // NOTE: every variable gets its hold/default value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    csn_d       = csn_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    vld_d       = 1'b0;
    sample_d    = sample_q;
    sample_ch_d = sample_ch_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    cont_d      = cont_q;
    dwell_d     = dwell_q;

    unique case (state_q)
      S_IDLE: begin
        csn_d  = 1'b1;
        busy_d = 1'b0;
        if (START && !STOP && (MASK != 8'd0)) begin
          mask_d  = MASK;
          cont_d  = CONT;
          dwell_d = DWELL;
          a_d     = lowest_set(MASK);
          csn_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = DWELL;
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (STOP) begin
          csn_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          sample_d    = Y_IN;
          sample_ch_d = a_q;
          vld_d       = 1'b1;
          if (!wrap || cont_q) begin
            a_d   = next_idx;
            cnt_d = dwell_q;
          end else begin
            csn_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      a_q         <= 3'd0;
      csn_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vld_q       <= 1'b0;
      sample_q    <= '0;
      sample_ch_q <= 3'd0;
      cnt_q       <= '0;
      mask_q      <= 8'd0;
      cont_q      <= 1'b0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      csn_q       <= csn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      vld_q       <= vld_d;
      sample_q    <= sample_d;
      sample_ch_q <= sample_ch_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      cont_q      <= cont_d;
      dwell_q     <= dwell_d;
    end
  end

  assign CSn        = csn_q;
  assign A          = a_q;
  assign SAMPLE     = sample_q;
  assign SAMPLE_CH  = sample_ch_q;
  assign SAMPLE_VLD = vld_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 8:1 mux where Dk = k+4.
module tb_mux_scan_ctrl;

  localparam int WIDTH   = 4;
  localparam int DWELL_W = 8;

  logic               CLK = 1'b0;
  logic               RSTn;
  logic               START;
  logic               STOP;
  logic               CONT;
  logic [7:0]         MASK;
  logic [DWELL_W-1:0] DWELL;
  logic [WIDTH-1:0]   Y_IN;
  logic               CSn;
  logic [2:0]         A;
  logic [WIDTH-1:0]   SAMPLE;
  logic [2:0]         SAMPLE_CH;
  logic               SAMPLE_VLD;
  logic               BUSY;
  logic               DONE;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  assign Y_IN = CSn ? 4'd0 : (4'(A) + 4'd4);

  mux_scan_ctrl #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .STOP(STOP), .CONT(CONT),
    .MASK(MASK), .DWELL(DWELL), .Y_IN(Y_IN), .CSn(CSn), .A(A),
    .SAMPLE(SAMPLE), .SAMPLE_CH(SAMPLE_CH), .SAMPLE_VLD(SAMPLE_VLD),
    .BUSY(BUSY), .DONE(DONE)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle; inputs set after this are seen at the next edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RSTn = 1'b0; START = 1'b0; STOP = 1'b0; CONT = 1'b0; MASK = 8'd0; DWELL = '0;
    step(2);
    check("rst_csn", CSn, 1); check("rst_a", A, 0); check("rst_sample", SAMPLE, 0);
    check("rst_ch", SAMPLE_CH, 0); check("rst_vld", SAMPLE_VLD, 0);
    check("rst_busy", BUSY, 0); check("rst_done", DONE, 0);
    RSTn = 1'b1;
    step();

    // Single pass over channels 0,2,7 with two cycles each.
    MASK = 8'b1000_0101; DWELL = 8'd1; CONT = 1'b0; START = 1'b1;
    step();
    START = 1'b0;
    check("t1_e0_csn", CSn, 0); check("t1_e0_a", A, 0); check("t1_e0_busy", BUSY, 1);
    step();
    check("t1_e1_a", A, 0); check("t1_e1_vld", SAMPLE_VLD, 0);
    step();
    check("t1_e2_vld", SAMPLE_VLD, 1); check("t1_e2_sample", SAMPLE, 4);
    check("t1_e2_ch", SAMPLE_CH, 0); check("t1_e2_a", A, 2);
    step();
    check("t1_e3_vld", SAMPLE_VLD, 0);
    step();
    check("t1_e4_vld", SAMPLE_VLD, 1); check("t1_e4_sample", SAMPLE, 6);
    check("t1_e4_ch", SAMPLE_CH, 2); check("t1_e4_a", A, 7);
    step();
    check("t1_e5_a", A, 7); check("t1_e5_done", DONE, 0); check("t1_e5_vld", SAMPLE_VLD, 0);
    step();
    check("t1_e6_vld", SAMPLE_VLD, 1); check("t1_e6_sample", SAMPLE, 11);
    check("t1_e6_ch", SAMPLE_CH, 7); check("t1_e6_done", DONE, 1);
    check("t1_e6_csn", CSn, 1); check("t1_e6_busy", BUSY, 0);
    step();
    check("t1_e7_done", DONE, 0); check("t1_e7_vld", SAMPLE_VLD, 0);
    check("t1_e7_sample", SAMPLE, 11); check("t1_e7_a", A, 7);

    // START with an empty mask is ignored.
    MASK = 8'd0; START = 1'b1;
    step();
    START = 1'b0;
    check("t4_m0_busy", BUSY, 0); check("t4_m0_done", DONE, 0); check("t4_m0_csn", CSn, 1);
    step();
    check("t4_m0_busy2", BUSY, 0);

    // Continuous single-channel scan at one cycle per channel, then STOP.
    MASK = 8'b0001_0000; DWELL = 8'd0; CONT = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    check("t2_e0_a", A, 4); check("t2_e0_csn", CSn, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_vld", SAMPLE_VLD, 1); check("t2_ch", SAMPLE_CH, 4);
      check("t2_sample", SAMPLE, 8); check("t2_csn", CSn, 0);
    end
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    check("t2_stop_csn", CSn, 1); check("t2_stop_busy", BUSY, 0);
    check("t2_stop_done", DONE, 0); check("t2_stop_vld", SAMPLE_VLD, 0);

    // STOP lands exactly on channel 5's capture edge.
    MASK = 8'hFF; DWELL = 8'd3; CONT = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    step(23);
    check("t3_pre_ch", SAMPLE_CH, 4); check("t3_pre_sample", SAMPLE, 8); check("t3_pre_a", A, 5);
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    check("t3_csn", CSn, 1); check("t3_busy", BUSY, 0); check("t3_vld", SAMPLE_VLD, 0);
    check("t3_ch", SAMPLE_CH, 4); check("t3_done", DONE, 0);
    step();
    check("t3_idle_busy", BUSY, 0);

    // Mid-scan changes to MASK/DWELL and a held START have no effect.
    MASK = 8'h03; DWELL = 8'd2; CONT = 1'b0; START = 1'b1;
    step();
    MASK = 8'hF0; DWELL = 8'd0;
    check("t6_e0_a", A, 0); check("t6_e0_busy", BUSY, 1);
    step(2);
    check("t6_e2_vld", SAMPLE_VLD, 0); check("t6_e2_a", A, 0);
    step();
    START = 1'b0;
    check("t6_e3_vld", SAMPLE_VLD, 1); check("t6_e3_ch", SAMPLE_CH, 0);
    check("t6_e3_sample", SAMPLE, 4); check("t6_e3_a", A, 1);
    step(2);
    check("t6_e5_vld", SAMPLE_VLD, 0); check("t6_e5_busy", BUSY, 1); check("t6_e5_a", A, 1);
    step();
    check("t6_e6_done", DONE, 1); check("t6_e6_vld", SAMPLE_VLD, 1);
    check("t6_e6_ch", SAMPLE_CH, 1); check("t6_e6_sample", SAMPLE, 5);
    check("t6_e6_csn", CSn, 1); check("t6_e6_busy", BUSY, 0);
    step();
    check("t6_e7_busy", BUSY, 0); check("t6_e7_done", DONE, 0);

    // Reset asserted for one edge while dwelling on channel 3.
    MASK = 8'h0C; DWELL = 8'd2; CONT = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    check("t5_e0_a", A, 2);
    step(3);
    check("t5_e3_a", A, 3); check("t5_e3_ch", SAMPLE_CH, 2); check("t5_e3_sample", SAMPLE, 6);
    RSTn = 1'b0;
    step();
    RSTn = 1'b1;
    check("t5_rst_csn", CSn, 1); check("t5_rst_a", A, 0); check("t5_rst_sample", SAMPLE, 0);
    check("t5_rst_ch", SAMPLE_CH, 0); check("t5_rst_vld", SAMPLE_VLD, 0);
    check("t5_rst_busy", BUSY, 0); check("t5_rst_done", DONE, 0);
    START = 1'b1;
    step();
    START = 1'b0;
    check("t5_restart_a", A, 2); check("t5_restart_csn", CSn, 0); check("t5_restart_busy", BUSY, 1);
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    check("t5_end_busy", BUSY, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
